serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//  Bit-serial subtraction controller: computes a - b - bin over WIDTH bits using one
//  1-bit full-subtract slice (two half-subtract stages), one bit per clock, LSB first.
//  Owns the operand shift registers, borrow flop, bit counter and start/done handshake.
//  Trades area for latency in front of any consumer of WIDTH-bit differences.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2); bit counter is $clog2(WIDTH) bits wide
// PORTS
//  clk         in   1      single clock, all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      request; sampled only in IDLE
//  a           in   WIDTH  minuend, captured on accepted start
//  b           in   WIDTH  subtrahend, captured on accepted start
//  bin         in   1      borrow-in, captured on accepted start
//  busy        out  1      high in RUN and DONE
//  done        out  1      one-cycle pulse, result valid
//  diff        out  WIDTH  (a - b - bin) mod 2^WIDTH
//  borrow_out  out  1      1 iff a < b + bin (unsigned)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, busy=0, done=0, diff=0, borrow_out=0,
//    counter=0, shift regs and borrow flop=0. Overrides all other inputs, any state.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: start=1 at edge -> capture a,b into shift regs, borrow flop<=bin,
//    counter<=0, state<=RUN. start=0 -> stay. diff/borrow_out hold previous result.
//  - RUN: each edge: d = a_sh[0]^b_sh[0]^brw; brw <= (~a_sh[0]&b_sh[0]) |
//    (~(a_sh[0]^b_sh[0])&brw); d shifted into MSB of result reg; a_sh,b_sh shift right.
//    counter increments; on edge where counter==WIDTH-1 -> state<=DONE.
//  - DONE: done=1 for exactly this cycle; diff=result reg, borrow_out=brw.
//    Next edge -> IDLE unconditionally.
//  - Latency: accepted start at edge N -> done high in cycle after edge N+WIDTH;
//    back in IDLE after edge N+WIDTH+1. Min start-to-start spacing WIDTH+2 cycles.
//  - start in RUN or DONE ignored (no queueing); a/b/bin changes after capture ignored.
//  - diff/borrow_out are registered; updated only at DONE entry; stable otherwise.
//  - busy/done are decoded from state register only (no combinational path from start).
//  - Reset mid-RUN: operation abandoned, no done pulse, diff/borrow_out cleared to 0.
//  - Wrap-around: all-borrow cases (e.g. 0-1) give 2^WIDTH-1 with borrow_out=1.
// TESTING (WIDTH=8)
//  1. a=0x05,b=0x03,bin=0,start 1 cycle -> busy next cycle, done after 9 edges, diff=0x02, borrow_out=0.
//  2. a=0x00,b=0x01,bin=0 -> diff=0xFF, borrow_out=1; a=0x80,b=0x80,bin=1 -> diff=0xFF, borrow_out=1.
//  3. a=0xFF,b=0x00,bin=0 -> diff=0xFF, borrow_out=0; a=0x3C,b=0x3C,bin=0 -> diff=0x00, borrow_out=0.
//  4. start held high with new a/b during RUN and DONE -> first result unchanged, exactly one done pulse,
//     second op begins only on the edge after return to IDLE.
//  5. rst at 3rd RUN cycle -> next cycle busy=0, done=0, diff=0; no done pulse; fresh start then gives correct result.
//  6. Random sweep 1000 ops vs {borrow,diff}={1'b0,a}-{1'b0,b}-bin; check done is exactly 1 cycle wide each op.

Source files
------------

// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if
//   Handshake and operand bundle for the bit-serial subtraction controller.
//   The master side (the requester) drives the start request and the operands.
//   The slave side (the controller) returns status and the registered result.
//
//   Signals
//     start       master -> slave  request; only honoured while the controller is idle
//     a           master -> slave  minuend, WIDTH bits
//     b           master -> slave  subtrahend, WIDTH bits
//     bin         master -> slave  borrow-in
//     busy        slave -> master  high while an operation is in flight or completing
//     done        slave -> master  one-cycle pulse marking a fresh result
//     diff        slave -> master  (a - b - bin) mod 2^WIDTH, held between operations
//     borrow_out  slave -> master  unsigned borrow of the last completed operation
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start,
    output a,
    output b,
    output bin,
    input  busy,
    input  done,
    input  diff,
    input  borrow_out
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  bin,
    output busy,
    output done,
    output diff,
    output borrow_out
  );

endinterface

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Bit-serial subtraction controller. Computes a - b - bin over WIDTH bits
//   with a single 1-bit full-subtract slice, one bit per clock, LSB first.
//   The slice is built from two half-subtract stages: the first combines the
//   operand bits, the second folds in the running borrow.
//
//   Ports
//     clk   in   single clock, every state update on the rising edge
//     rst   in   synchronous active-high reset, overrides everything
//     bus   slave modport of serial_sub_ctrl_if
//             start/a/b/bin in, busy/done/diff/borrow_out out
//
//   Timing
//     A start accepted at edge N enters RUN; WIDTH further edges process the
//     bits and the last of them enters DONE, so done is high in the cycle
//     after edge N+WIDTH and the controller is idle again after edge
//     N+WIDTH+1. Requests seen outside IDLE are dropped, not queued.
//
//   Outputs
//     busy/done are registered copies of the state decode, so there is no
//     combinational path from start to any output. diff/borrow_out only
//     change on entry to DONE (or on reset) and hold otherwise.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_sub_ctrl_if.slave bus
);

  // Counter only has to reach WIDTH-1; keep at least one bit for tiny widths.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic             brw_q,   brw_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] diff_q,  diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             a_bit;
  logic             b_bit;
  logic             half_diff;
  logic             half_brw;
  logic             d_bit;
  logic             brw_next;
  logic [WIDTH-1:0] res_shifted;

  // The 1-bit full-subtract slice, written as two half-subtract stages.
  // Stage one: a_bit - b_bit gives a partial difference and partial borrow.
  // Stage two: subtract the running borrow from the partial difference; its
  // borrow can only occur when the partial difference is 0, so the two
  // borrow terms are mutually exclusive and a plain OR merges them.
  always_comb begin
    a_bit     = a_sh_q[0];
    b_bit     = b_sh_q[0];
    half_diff = a_bit ^ b_bit;
    half_brw  = ~a_bit & b_bit;
    d_bit     = half_diff ^ brw_q;
    brw_next  = half_brw | (~half_diff & brw_q);
  end

  // The minuend register doubles as the result register: each cycle the
  // consumed LSB falls off the bottom and the new difference bit enters at
  // the top, so after WIDTH shifts it holds the full difference LSB-aligned.
  always_comb begin
    res_shifted = {d_bit, a_sh_q[WIDTH-1:1]};
  end

  // Next-state logic for the FSM and the datapath registers.
  // Everything holds by default; only the state-specific branches move data.
  // busy/done are derived from the next state so that, once registered, they
  // line up exactly with the state they describe.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = bus.bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d = res_shifted;
        b_sh_d = b_sh_q >> 1;
        brw_d  = brw_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d   = res_shifted;
          borrow_d = brw_next;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers. Reset wins over every other input in every
  // state, abandoning any operation in flight and clearing the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl
//   Self-checking bench for serial_sub_ctrl at WIDTH=8: a table of directed
//   vectors, hand-written sequences for held start and mid-operation reset,
//   and a randomized sweep scored against an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_borrow;
  } vec_t;

  vec_t       vecs[10];
  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] prev_diff    = 8'h00;

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: unsigned subtraction in WIDTH+1 bits; the top bit is the borrow.
  function automatic logic [8:0] refSub(input logic [7:0] a, input logic [7:0] b,
                                        input logic bin);
    return {1'b0, a} - {1'b0, b} - {8'd0, bin};
  endfunction

  // Wait (bounded) for a done pulse; lat = cycles since acceptance, 0 on timeout.
  task automatic waitDone(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (bus.done) begin
          seen = 1'b1;
          lat  = k;
        end
      end
    end
  endtask

  // One complete operation: pulse start, scramble the inputs after capture,
  // then check busy, latency, result, pulse width and result hold.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin,
                               input logic [7:0] exp_diff, input logic exp_borrow,
                               input string tag);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    bus.bin   = 1'($urandom);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, " diff held in RUN"}, 32'(bus.diff), 32'(prev_diff));
    waitDone(lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(WIDTH));
    checkOutput({tag, " diff"}, 32'(bus.diff), 32'(exp_diff));
    checkOutput({tag, " borrow_out"}, 32'(bus.borrow_out), 32'(exp_borrow));
    @(negedge clk);
    checkOutput({tag, " done width"}, 32'(bus.done), 32'd0);
    checkOutput({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " diff hold"}, 32'(bus.diff), 32'(exp_diff));
    prev_diff = exp_diff;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         lat;
    int         done_cnt;
    int         done_k;
    logic [8:0] r;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
    vecs[8] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[9] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset diff", 32'(bus.diff), 32'd0);
    checkOutput("reset borrow_out", 32'(bus.borrow_out), 32'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff,
                    vecs[i].exp_borrow, $sformatf("vec%0d", i));
    end

    // start held high with changing operands through RUN and DONE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.a     = 8'h55;
    bus.b     = 8'h22;
    bus.bin   = 1'b1;
    done_cnt  = 0;
    done_k    = 0;
    for (int k = 1; k <= WIDTH + 1; k++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        done_k = k;
        checkOutput("held diff", 32'(bus.diff), 32'h0F);
        checkOutput("held borrow_out", 32'(bus.borrow_out), 32'd0);
      end
    end
    checkOutput("held done count", 32'(done_cnt), 32'd1);
    checkOutput("held latency", 32'(done_k), 32'(WIDTH));
    checkOutput("held idle busy", 32'(bus.busy), 32'd0);
    checkOutput("held idle diff", 32'(bus.diff), 32'h0F);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("held second busy", 32'(bus.busy), 32'd1);
    waitDone(lat);
    checkOutput("held second latency", 32'(lat), 32'(WIDTH));
    checkOutput("held second diff", 32'(bus.diff), 32'h32);
    checkOutput("held second borrow_out", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    prev_diff = 8'h32;

    // Reset asserted during the third RUN cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h09;
    bus.b     = 8'h04;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst busy", 32'(bus.busy), 32'd0);
    checkOutput("rst done", 32'(bus.done), 32'd0);
    checkOutput("rst diff", 32'(bus.diff), 32'd0);
    checkOutput("rst borrow_out", 32'(bus.borrow_out), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < WIDTH + 3; k++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    checkOutput("rst no done pulse", 32'(done_cnt), 32'd0);
    prev_diff = 8'h00;
    applyStimulus(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, "post-rst");

    // Randomized sweep against the arithmetic model.
    for (int n = 0; n < 1000; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      if (n % 50 == 0) ra = rb;
      r = refSub(ra, rb, rbin);
      applyStimulus(ra, rb, rbin, r[7:0], r[8], $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
